// File: rtl/hpdcache_common_pkg.sv
// Shared hpdcache helpers reusable across cache blocks.
// Holds the one-hot to binary index conversion.
package hpdcache_common_pkg;

   localparam int unsigned HPDCACHE_1HOT_MAXW = 64;
   localparam int unsigned HPDCACHE_1HOT_BINW = 6;

   // Callers zero-extend their vector to MAXW and truncate the result to their index width.
   // A non-one-hot input returns the OR of all set positions.
   function automatic logic [HPDCACHE_1HOT_BINW-1:0] hpdcache_1hot_to_binary(
      input logic [HPDCACHE_1HOT_MAXW-1:0] onehot
   );
      logic [HPDCACHE_1HOT_BINW-1:0] bin;
      bin = '0;
      for (int i = 0; i < int'(HPDCACHE_1HOT_MAXW); i++) begin
         if (onehot[i]) bin = bin | HPDCACHE_1HOT_BINW'(i);
      end
      return bin;
   endfunction

endpackage

// File: rtl/hpdcache_prio_1hot_encoder.sv
// Priority encoder: returns the lowest set bit of val_i as a one-hot vector.
// Bit 0 has the highest priority.
module hpdcache_prio_1hot_encoder #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] val_i,
   output logic [N-1:0] val_o
);

   // Two's-complement trick isolates the least significant set bit.
   assign val_o = val_i & (~val_i + N'(1));

endmodule

// File: rtl/hpdcache_1hot_serializer.sv
// Serializes a multi-hot request mask into one index per handshake, lowest bit first.
// A new mask can be taken in the same cycle the last index is consumed.
module hpdcache_1hot_serializer
   import hpdcache_common_pkg::*;
#(
   parameter  int unsigned N    = 8,
   localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            abort_i,
   input  logic            mask_valid_i,
   output logic            mask_ready_o,
   input  logic [N-1:0]    mask_i,
   output logic            idx_valid_o,
   input  logic            idx_ready_i,
   output logic [IDXW-1:0] idx_o,
   output logic [N-1:0]    idx_1hot_o,
   output logic            idx_last_o
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   pending_q, pending_d;
   logic [N-1:0]   sel_1hot;
   logic           busy;
   logic           last;
   logic           mask_hs;
   logic           idx_hs;
   logic [HPDCACHE_1HOT_BINW-1:0] sel_bin;

   hpdcache_prio_1hot_encoder #(
      .N (N)
   ) prio_enc_i (
      .val_i (pending_q),
      .val_o (sel_1hot)
   );

   assign sel_bin = hpdcache_1hot_to_binary(HPDCACHE_1HOT_MAXW'(sel_1hot));
   assign busy    = (state_q == BUSY);
   // Pending is never zero in BUSY, so "nothing left after the selected bit" means exactly one bit.
   assign last    = ((pending_q & ~sel_1hot) == '0);

   // Handshakes: a transfer happens in a cycle where both valid and ready are high;
   // the producer must hold its payload while valid is high and ready is low.
   assign idx_valid_o  = busy;
   assign idx_1hot_o   = busy ? sel_1hot : '0;
   assign idx_o        = busy ? sel_bin[IDXW-1:0] : '0;
   assign idx_last_o   = busy & last;
   assign mask_ready_o = ~abort_i & (~busy | (idx_last_o & idx_ready_i));

   assign mask_hs = mask_valid_i & mask_ready_o;
   assign idx_hs  = idx_valid_o & idx_ready_i;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      if (abort_i) begin
         state_d   = IDLE;
         pending_d = '0;
      end else begin
         if (idx_hs) begin
            pending_d = pending_q & ~sel_1hot;
            if (idx_last_o) state_d = IDLE;
         end
         // A zero mask is consumed without leaving IDLE.
         if (mask_hs && (mask_i != '0)) begin
            pending_d = mask_i;
            state_d   = BUSY;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

endmodule

// File: tb/tb_hpdcache_1hot_serializer.sv
// Directed bench for hpdcache_1hot_serializer with N=8.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_hpdcache_1hot_serializer;

  localparam int unsigned N = 8;
  localparam int unsigned IDXW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            abort = 1'b0;
  logic            mask_valid = 1'b0;
  logic            mask_ready;
  logic [N-1:0]    mask = '0;
  logic            idx_valid;
  logic            idx_ready = 1'b0;
  logic [IDXW-1:0] idx;
  logic [N-1:0]    idx_1hot;
  logic            idx_last;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  hpdcache_1hot_serializer #(.N(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .abort_i      (abort),
    .mask_valid_i (mask_valid),
    .mask_ready_o (mask_ready),
    .mask_i       (mask),
    .idx_valid_o  (idx_valid),
    .idx_ready_i  (idx_ready),
    .idx_o        (idx),
    .idx_1hot_o   (idx_1hot),
    .idx_last_o   (idx_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic v, input logic [IDXW-1:0] i,
                           input logic [N-1:0] oh, input logic l, input logic r);
    check({tag, ".valid"}, 32'(idx_valid), 32'(v));
    check({tag, ".idx"},   32'(idx),       32'(i));
    check({tag, ".1hot"},  32'(idx_1hot),  32'(oh));
    check({tag, ".last"},  32'(idx_last),  32'(l));
    check({tag, ".ready"}, 32'(mask_ready), 32'(r));
  endtask

  // Advance to the next edge, leaving time to change inputs before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    tick(); tick();
    rst = 1'b0;
    #1 check_out("reset", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);

    // Basic serialization of 8'b1010_0110
    tick();
    mask_valid = 1'b1; mask = 8'hA6; idx_ready = 1'b1;
    #1 check("t1.ready_idle", 32'(mask_ready), 32'd1);
    tick();
    mask_valid = 1'b0; mask = 8'h00;
    #1 check_out("t1.i1", 1'b1, 3'd1, 8'h02, 1'b0, 1'b0);
    tick();
    #1 check_out("t1.i2", 1'b1, 3'd2, 8'h04, 1'b0, 1'b0);
    tick();
    #1 check_out("t1.i5", 1'b1, 3'd5, 8'h20, 1'b0, 1'b0);
    tick();
    #1 check_out("t1.i7", 1'b1, 3'd7, 8'h80, 1'b1, 1'b1);
    tick();
    #1 check_out("t1.idle", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);

    // Backpressure on 8'b0000_1001, with mask_i wiggling while BUSY
    idx_ready = 1'b0; mask_valid = 1'b1; mask = 8'h09;
    tick();
    mask_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mask = 8'(c * 8'h55 + 8'h0F);
      #1 check_out("t2.hold", 1'b1, 3'd0, 8'h01, 1'b0, 1'b0);
      tick();
    end
    mask = 8'h00; idx_ready = 1'b1;
    #1 check_out("t2.i0", 1'b1, 3'd0, 8'h01, 1'b0, 1'b0);
    tick();
    #1 check_out("t2.i3", 1'b1, 3'd3, 8'h08, 1'b1, 1'b1);
    tick();
    #1 check_out("t2.idle", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);

    // Back-to-back masks: 8'h80 then 8'h03 at the last handshake
    mask_valid = 1'b1; mask = 8'h80;
    tick();
    mask = 8'h03;
    #1 check_out("t3.i7", 1'b1, 3'd7, 8'h80, 1'b1, 1'b1);
    tick();
    mask_valid = 1'b0; mask = 8'h00;
    #1 check_out("t3.i0", 1'b1, 3'd0, 8'h01, 1'b0, 1'b0);
    tick();
    #1 check_out("t3.i1", 1'b1, 3'd1, 8'h02, 1'b1, 1'b1);
    tick();
    #1 check_out("t3.idle", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);

    // Zero mask is consumed and dropped
    mask_valid = 1'b1; mask = 8'h00;
    #1 check("t4.ready", 32'(mask_ready), 32'd1);
    tick();
    mask_valid = 1'b0;
    #1 check_out("t4.idle", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);

    // Abort after the first index of 8'hFF; the mask offered alongside is refused
    mask_valid = 1'b1; mask = 8'hFF;
    tick();
    mask_valid = 1'b0;
    #1 check_out("t5.i0", 1'b1, 3'd0, 8'h01, 1'b0, 1'b0);
    tick();
    abort = 1'b1; mask_valid = 1'b1; mask = 8'h04;
    #1 check_out("t5.abort", 1'b1, 3'd1, 8'h02, 1'b0, 1'b0);
    tick();
    abort = 1'b0; mask_valid = 1'b0; mask = 8'h00;
    #1 check_out("t5.idle", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    tick();
    #1 check_out("t5.idle2", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);

    // Reset while BUSY with pending 8'hF0, then a fresh mask
    idx_ready = 1'b0; mask_valid = 1'b1; mask = 8'hF0;
    tick();
    mask_valid = 1'b0; mask = 8'h00;
    #1 check_out("t6.i4", 1'b1, 3'd4, 8'h10, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 check_out("t6.rst", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    mask_valid = 1'b1; mask = 8'h04; idx_ready = 1'b1;
    tick();
    mask_valid = 1'b0; mask = 8'h00;
    #1 check_out("t6.i2", 1'b1, 3'd2, 8'h04, 1'b1, 1'b1);
    tick();
    #1 check_out("t6.idle", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
